// File: rtl/dram_wr_pkg.sv
// dram_wr_pkg: shared constants, types and helpers for the DRAM write engine.
// Holds the AXI4 encodings, the stream field widths, the burst FSM state
// type and the burst-length clamp helper.
package dram_wr_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int LEN_MAX = 64;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int CMD_W   = 40;
  localparam int WORD_W  = DATA_W + STRB_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // Limit a requested burst length to the largest legal burst.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] lmax);
    logic [7:0] res;
    if (len > lmax) begin
      res = lmax;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
// Ports: push/din write a word, pop consumes the head shown on dout,
// full/empty/count report occupancy (count is AW+1 bits, 0..2**AW).
// A push on a full FIFO is only taken when a pop happens in the same cycle.
module sync_fifo_fwft
  import dram_wr_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dram_write_engine.sv
// dram_write_engine: turns the capture stage's buffered data words
// {strb,data} and burst commands {len,addr} into AXI4 INCR write bursts.
// Ports: data_in/data_we and ctrl_in/ctrl_we push into internal FIFOs
// (data_full/ctrl_full report occupancy); m_aw*/m_w*/m_b* form the AXI4
// write channels; busy, err_resp (sticky non-OKAY response) and err_ovf
// (sticky dropped push or clamped length) give status.
// A burst is only started once every beat it needs is already buffered.
module dram_write_engine
  import dram_wr_pkg::*;
#(
  parameter int DFIFO_AW = 8,
  parameter int CFIFO_AW = 4,
  parameter int LEN_MAX  = dram_wr_pkg::LEN_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] data_in,
  input  logic        data_we,
  input  logic [39:0] ctrl_in,
  input  logic        ctrl_we,
  output logic        data_full,
  output logic        ctrl_full,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        busy,
  output logic        err_resp,
  output logic        err_ovf
);

  localparam logic [7:0] LEN_MAX_B = 8'(LEN_MAX);

  wr_state_e state_q, state_d;

  logic [35:0]       d_dout_s;
  logic              d_full_s, d_empty_s, d_pop_s;
  logic [DFIFO_AW:0] d_count_s;
  logic [39:0]       c_dout_s;
  logic              c_full_s, c_empty_s, c_pop_s;
  logic [CFIFO_AW:0] c_count_s;

  logic [31:0] awaddr_q;
  logic [7:0]  awlen_q, beat_q;
  logic        awvalid_q, wvalid_q, wlast_q, bready_q, err_resp_q, err_ovf_q;

  logic [7:0]  cmd_len_s, len_eff_s;
  logic [31:0] cmd_addr_s;
  logic        cmd_valid_s, cmd_skip_s, cmd_go_s, enough_s;
  logic        aw_hs_s, w_hs_s, b_hs_s, ovf_event_s;

  sync_fifo_fwft #(.WIDTH(WORD_W), .AW(DFIFO_AW)) u_data_fifo (
    .clk(clk), .rst_n(rst_n), .push(data_we), .pop(d_pop_s), .din(data_in),
    .dout(d_dout_s), .full(d_full_s), .empty(d_empty_s), .count(d_count_s)
  );

  sync_fifo_fwft #(.WIDTH(CMD_W), .AW(CFIFO_AW)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n), .push(ctrl_we), .pop(c_pop_s), .din(ctrl_in),
    .dout(c_dout_s), .full(c_full_s), .empty(c_empty_s), .count(c_count_s)
  );

  assign cmd_len_s   = c_dout_s[39:32];
  assign cmd_addr_s  = c_dout_s[31:0];
  assign len_eff_s   = clamp_len(cmd_len_s, LEN_MAX_B);
  assign enough_s    = (32'(d_count_s) >= 32'(len_eff_s));
  assign cmd_valid_s = (state_q == ST_IDLE) & ~c_empty_s;
  // Zero-length commands are retired without any bus traffic.
  assign cmd_skip_s  = cmd_valid_s & (cmd_len_s == 8'd0);
  assign cmd_go_s    = cmd_valid_s & (cmd_len_s != 8'd0) & enough_s;
  assign c_pop_s     = cmd_skip_s | cmd_go_s;

  assign aw_hs_s = awvalid_q & m_awready;
  assign w_hs_s  = wvalid_q & m_wready;
  assign b_hs_s  = bready_q & m_bvalid;
  assign d_pop_s = w_hs_s & ~d_empty_s;

  // Dropped pushes and over-long commands both flag an overflow.
  assign ovf_event_s = (data_we & d_full_s & ~d_pop_s) |
                       (ctrl_we & c_full_s & ~c_pop_s) |
                       (cmd_go_s & (cmd_len_s > LEN_MAX_B));

  assign data_full = d_full_s;
  assign ctrl_full = c_full_s;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awsize  = AXI_SIZE_4B;
  assign m_awburst = AXI_BURST_INCR;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = d_dout_s[31:0];
  assign m_wstrb   = d_dout_s[35:32];
  assign m_wlast   = wlast_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign busy      = (state_q != ST_IDLE) | (c_count_s != {(CFIFO_AW+1){1'b0}});
  assign err_resp  = err_resp_q;
  assign err_ovf   = err_ovf_q;

  // Burst FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst FSM next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_go_s) state_d = ST_ADDR;
        else          state_d = ST_IDLE;
      end
      ST_ADDR: begin
        if (aw_hs_s) state_d = ST_DATA;
        else         state_d = ST_ADDR;
      end
      ST_DATA: begin
        if (w_hs_s && wlast_q) state_d = ST_RESP;
        else                   state_d = ST_DATA;
      end
      ST_RESP: begin
        if (b_hs_s) state_d = ST_IDLE;
        else        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered AXI channel outputs, beat counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q   <= 32'h0000_0000;
      awlen_q    <= 8'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      beat_q     <= 8'd0;
      bready_q   <= 1'b0;
      err_resp_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_go_s) begin
            awaddr_q  <= cmd_addr_s;
            awlen_q   <= len_eff_s - 8'd1;
            awvalid_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (aw_hs_s) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= 8'd0;
            wlast_q   <= (awlen_q == 8'd0);
          end
        end
        ST_DATA: begin
          if (w_hs_s) begin
            beat_q <= beat_q + 8'd1;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              // Look one beat ahead so wlast is valid when that beat is shown.
              wlast_q <= ((beat_q + 8'd1) == awlen_q);
            end
          end
        end
        ST_RESP: begin
          if (b_hs_s) begin
            bready_q <= 1'b0;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          wlast_q   <= 1'b0;
          bready_q  <= 1'b0;
        end
      endcase
      if (b_hs_s && (m_bresp != AXI_RESP_OKAY)) begin
        err_resp_q <= 1'b1;
      end
      if (ovf_event_s) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_write_engine.sv
// tb_dram_write_engine: directed stimulus with a scoreboard.  Stimulus pushes
// expected AW and W entries (derived from a model of the data FIFO) into
// queues; a monitor compares every presented AW/W beat against the queue heads.
module tb_dram_write_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we;
  logic        data_full, ctrl_full;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        busy, err_resp, err_ovf;

  always #5 clk = ~clk;

  dram_write_engine #(.DFIFO_AW(8), .CFIFO_AW(4), .LEN_MAX(64)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we),
    .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .data_full(data_full), .ctrl_full(ctrl_full),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy), .err_resp(err_resp),
    .err_ovf(err_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] model_q [$];
  logic [39:0] exp_aw [$];
  logic [36:0] exp_w [$];
  int exp_b = 0;
  int b_seen = 0;
  int b_owed = 0;
  int aw_delay = 0;
  bit wtoggle = 1'b0;
  bit whold = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [35:0] w);
    data_in = w;
    data_we = 1'b1;
    if (model_q.size() < 256) model_q.push_back(w);
    @(posedge clk); #1;
    data_we = 1'b0;
  endtask

  task automatic push_cmd(input logic [7:0] len, input logic [31:0] addr);
    ctrl_in = {len, addr};
    ctrl_we = 1'b1;
    @(posedge clk); #1;
    ctrl_we = 1'b0;
  endtask

  // Expected AW and W beats for a burst, taken from the buffered word model.
  task automatic expect_burst(input logic [31:0] addr, input int len);
    int l;
    logic [35:0] w;
    bit lst;
    l = (len > 64) ? 64 : len;
    exp_aw.push_back({8'(l - 1), addr});
    for (int i = 0; i < l; i++) begin
      w = model_q.pop_front();
      lst = (i == l - 1);
      exp_w.push_back({lst, w});
    end
    exp_b++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && (busy || exp_aw.size() != 0 || exp_w.size() != 0 ||
                          b_owed != 0 || m_bvalid || exp_b != b_seen)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: waited %0d cycles, required completion", name, k);
    end else begin
      chk({name, "_bcount"}, 64'(b_seen), 64'(exp_b));
      chk({name, "_busy"}, 64'(busy), 64'(0));
    end
  endtask

  // AXI slave model: ready patterns and write responses.
  initial begin
    bit awv, awhs, wlhs, bhs;
    int aw_wait;
    aw_wait = 0;
    m_awready = 1'b1;
    m_wready = 1'b1;
    m_bvalid = 1'b0;
    m_bresp = 2'b00;
    forever begin
      @(negedge clk);
      awv  = m_awvalid;
      awhs = m_awvalid && m_awready;
      wlhs = m_wvalid && m_wready && m_wlast;
      bhs  = m_bvalid && m_bready;
      @(posedge clk); #1;
      if (!rst_n) begin
        aw_wait = 0;
        b_owed = 0;
        m_bvalid = 1'b0;
        m_awready = (aw_delay == 0);
        m_wready = !whold;
      end else begin
        if (awhs) aw_wait = 0;
        else if (awv) aw_wait++;
        m_awready = (aw_wait >= aw_delay);
        if (whold) m_wready = 1'b0;
        else if (wtoggle) m_wready = !m_wready;
        else m_wready = 1'b1;
        if (bhs) m_bvalid = 1'b0;
        if (wlhs) b_owed++;
        if (!m_bvalid && b_owed > 0) begin
          m_bvalid = 1'b1;
          m_bresp = bresp_cfg;
          b_owed--;
        end
      end
    end
  end

  // Monitor: compare every presented AW and W against the scoreboard heads.
  initial begin
    logic [39:0] a;
    logic [36:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_awvalid) begin
          if (exp_aw.size() == 0) begin
            chk("aw_unexpected", 64'(m_awvalid), 64'(0));
          end else begin
            a = exp_aw[0];
            chk("aw_addr", 64'(m_awaddr), 64'(a[31:0]));
            chk("aw_len", 64'(m_awlen), 64'(a[39:32]));
            chk("aw_size", 64'(m_awsize), 64'(3'b010));
            chk("aw_burst", 64'(m_awburst), 64'(2'b01));
            if (m_awready) void'(exp_aw.pop_front());
          end
        end
        if (m_wvalid) begin
          if (exp_w.size() == 0) begin
            chk("w_unexpected", 64'(m_wvalid), 64'(0));
          end else begin
            w = exp_w[0];
            chk("w_data", 64'(m_wdata), 64'(w[31:0]));
            chk("w_strb", 64'(m_wstrb), 64'(w[35:32]));
            chk("w_last", 64'(m_wlast), 64'(w[36]));
            if (m_wready) void'(exp_w.pop_front());
          end
        end
        if (m_bvalid && m_bready) b_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    data_in = 36'h0;
    data_we = 1'b0;
    ctrl_in = 40'h0;
    ctrl_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", 64'(m_awvalid), 64'(0));
    chk("rst_wvalid", 64'(m_wvalid), 64'(0));
    chk("rst_wlast", 64'(m_wlast), 64'(0));
    chk("rst_bready", 64'(m_bready), 64'(0));
    chk("rst_awaddr", 64'(m_awaddr), 64'(0));
    chk("rst_awlen", 64'(m_awlen), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data_full", 64'(data_full), 64'(0));
    chk("rst_ctrl_full", 64'(ctrl_full), 64'(0));
    chk("rst_err_resp", 64'(err_resp), 64'(0));
    chk("rst_err_ovf", 64'(err_ovf), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-beat burst with data already buffered; AW two cycles after ctrl_we.
    for (int i = 0; i < 64; i++) push_word({4'hF, 32'(i)});
    expect_burst(32'h0000_1900, 64);
    push_cmd(8'd64, 32'h0000_1900);
    chk("lat_aw_early", 64'(m_awvalid), 64'(0));
    @(posedge clk); #1;
    chk("lat_aw_2cyc", 64'(m_awvalid), 64'(1));
    wait_idle("t1", 300);

    // Command ahead of its data: AW must wait for the fifth word.
    push_cmd(8'd5, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      push_word({4'(i + 1), 32'hA000_0000 + 32'(i)});
      repeat (2) @(posedge clk);
      #1;
      chk("t2_no_aw", 64'(m_awvalid), 64'(0));
    end
    push_word({4'h5, 32'hA000_0004});
    expect_burst(32'h0000_0100, 5);
    wait_idle("t2", 100);

    // Zero-length command is skipped silently.
    push_cmd(8'd0, 32'h0000_0200);
    push_cmd(8'd2, 32'h0000_0300);
    push_word({4'h3, 32'hB000_0000});
    push_word({4'hC, 32'hB000_0001});
    expect_burst(32'h0000_0300, 2);
    wait_idle("t3", 100);
    chk("t3_err_ovf", 64'(err_ovf), 64'(0));
    chk("t3_err_resp", 64'(err_resp), 64'(0));

    // Back-pressure: AW ready late, W ready alternating.
    aw_delay = 7;
    wtoggle = 1'b1;
    for (int i = 0; i < 6; i++) push_word({4'(9 + i), 32'hC0DE_0000 + 32'(i * 3)});
    expect_burst(32'h0000_0400, 6);
    push_cmd(8'd6, 32'h0000_0400);
    wait_idle("t4", 200);
    aw_delay = 0;
    wtoggle = 1'b0;

    // SLVERR response sets the sticky error, which survives a later OKAY burst.
    bresp_cfg = 2'b10;
    push_word({4'h1, 32'hDEAD_BEEF});
    expect_burst(32'h0000_0500, 1);
    push_cmd(8'd1, 32'h0000_0500);
    wait_idle("t5a", 100);
    chk("t5_err_resp_set", 64'(err_resp), 64'(1));
    bresp_cfg = 2'b00;
    push_word({4'h2, 32'h1234_5678});
    expect_burst(32'h0000_0504, 1);
    push_cmd(8'd1, 32'h0000_0504);
    wait_idle("t5b", 100);
    chk("t5_err_resp_sticky", 64'(err_resp), 64'(1));

    // Overfill the data FIFO: 256 accepted, 257th dropped.
    chk("t6_ovf_before", 64'(err_ovf), 64'(0));
    for (int i = 0; i < 255; i++) push_word({4'hF, 32'h5500_0000 + 32'(i)});
    chk("t6_not_full_255", 64'(data_full), 64'(0));
    push_word({4'hF, 32'h5500_00FF});
    chk("t6_full_256", 64'(data_full), 64'(1));
    chk("t6_ovf_256", 64'(err_ovf), 64'(0));
    push_word({4'hF, 32'h6600_0000});
    chk("t6_ovf_257", 64'(err_ovf), 64'(1));
    chk("t6_full_257", 64'(data_full), 64'(1));

    // Reset in the middle of a stalled W phase.
    whold = 1'b1;
    expect_burst(32'h0000_0600, 4);
    push_cmd(8'd4, 32'h0000_0600);
    begin
      int k;
      k = 0;
      while (!m_wvalid && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      chk("t7_reached_data", 64'(m_wvalid), 64'(1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_wvalid", 64'(m_wvalid), 64'(0));
    chk("t7_rst_wlast", 64'(m_wlast), 64'(0));
    chk("t7_rst_awvalid", 64'(m_awvalid), 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    chk("t7_rst_full", 64'(data_full), 64'(0));
    chk("t7_rst_err_ovf", 64'(err_ovf), 64'(0));
    chk("t7_rst_err_resp", 64'(err_resp), 64'(0));
    exp_aw.delete();
    exp_w.delete();
    model_q.delete();
    exp_b = 0;
    b_seen = 0;
    whold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_post_idle", 64'(m_wvalid), 64'(0));

    // Fresh burst after reset must see only newly written words.
    push_word({4'h7, 32'h7700_0001});
    push_word({4'h8, 32'h7700_0002});
    expect_burst(32'h0000_0700, 2);
    push_cmd(8'd2, 32'h0000_0700);
    wait_idle("t8", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
